dp_memory_checker: RTL and testbench
====================================

DP_MEMORY_CHECKER -- requirements
Module: dp_memory_checker

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the data bus width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4, meaning the address width; model depth is 2**ADDR_WIDTH.
REQ-003 The block SHALL have parameter RD_LATENCY, default 1, legal range 1..4, meaning the cycles from read issue to valid DUT dout.
REQ-004 The block SHALL have parameter CNT_WIDTH, default 16, meaning the width of every status counter.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit, reset; it is asynchronous and active-low.
REQ-007 The block SHALL have ports a_we / b_we, input, 1 bit each, port A/B write enable; 0 means a read is issued.
REQ-008 The block SHALL have ports a_addr / b_addr, input, ADDR_WIDTH bits each, port A/B address.
REQ-009 The block SHALL have ports a_din / b_din, input, DATA_WIDTH bits each, port A/B write data.
REQ-010 The block SHALL have ports a_dout / b_dout, input, DATA_WIDTH bits each, the DUT read data for port A/B.
REQ-011 The block SHALL have port clear, input, 1 bit, a synchronous clear of the status outputs.
REQ-012 The block SHALL have port err_sticky, output, 1 bit, set on any mismatch.
REQ-013 The block SHALL have ports check_cnt, mismatch_cnt and collision_cnt, output, CNT_WIDTH bits each.
REQ-014 The block SHALL have port first_err_valid, output, 1 bit, set when the first-error fields hold a capture.
REQ-015 The block SHALL have ports first_err_port (1 bit, 0=A, 1=B), first_err_addr (ADDR_WIDTH bits), first_err_exp (DATA_WIDTH bits) and first_err_got (DATA_WIDTH bits), all outputs.

Function
REQ-016 The block SHALL keep a model array and a per-address valid bitmap.
REQ-017 A write at cycle t SHALL update model[addr] and set valid[addr] at the edge ending cycle t.
REQ-018 A read at cycle t SHALL capture expected = model[addr] as of before the cycle-t writes, together with valid[addr] and the address.
REQ-019 Each read SHALL be delayed through an RD_LATENCY-stage pipe per port and compared against that port's dout in cycle t+RD_LATENCY.
REQ-020 A compare SHALL be performed only if the captured valid bit is 1 and the entry is not flagged as a collision.
REQ-021 Each performed compare SHALL increment check_cnt by 1.
REQ-022 A performed compare with dout !== expected SHALL increment mismatch_cnt and set err_sticky; X or Z on dout counts as a mismatch.
REQ-023 If both ports compare in the same cycle, both SHALL be counted, so the counters advance by up to 2 per cycle.
REQ-024 The first-error fields SHALL capture only the first mismatch after reset or clear, then hold.
REQ-025 If A and B both mismatch in the first-error cycle, port A SHALL be captured.
REQ-026 A same-address write from both ports in one cycle SHALL increment collision_cnt by 1, leave the model unchanged, and clear valid[addr].
REQ-027 A read on one port of the address being written by the other port in the same cycle SHALL be marked as a collision, skip its compare, and increment collision_cnt.
REQ-028 All counters SHALL saturate at all-ones and never wrap.
REQ-029 clear SHALL zero the counters, err_sticky and the first-error fields at the next edge.
REQ-030 clear SHALL NOT alter the model, the valid bitmap or in-flight pipe entries; those entries compare and count normally after the clear.
REQ-031 clear asserted in the same cycle as a compare event SHALL take priority: the counters read 0 after that edge.

Reset
REQ-032 On rst_n=0 the block SHALL immediately zero all counters, err_sticky, first_err_valid and all first-error fields.
REQ-033 On rst_n=0 the block SHALL immediately clear the valid bitmap and empty both pipes; model contents are don't-care.
REQ-034 Reset asserted mid-operation SHALL discard in-flight reads, with no compare for any read issued before reset.

Configuration
REQ-035 With macro MEM_CHK_UNINIT_FLAG_EN defined, the block SHALL add output uninit_cnt (CNT_WIDTH bits, saturating, reset 0, zeroed by clear).
REQ-036 With MEM_CHK_UNINIT_FLAG_EN defined, uninit_cnt SHALL count matured reads whose captured valid bit was 0, excluding collision entries.
REQ-037 Without MEM_CHK_UNINIT_FLAG_EN, the uninit_cnt port and its logic SHALL be absent and such reads SHALL be silently skipped.

Structure
REQ-038 Package mem_chk_pkg SHALL hold the port-id typedef (PORT_A=0, PORT_B=1), the pipe-entry struct (valid, collision, addr, exp) and the saturating-increment function.
REQ-039 The delay line SHALL be sub-module chk_pipe, parameterised by RD_LATENCY and the entry width, and instantiated once per port.

Verification
REQ-040 Scenario (DW=8, AW=4, RD_LATENCY=2): write A addr3=0xA5, read B addr3, drive b_dout=0xA5 two cycles later -> check_cnt=1, mismatch_cnt=0, err_sticky=0.
REQ-041 Scenario: as REQ-040 but b_dout=0x5A -> mismatch_cnt=1, err_sticky=1, first_err = {port B, addr 3, exp 0xA5, got 0x5A}.
REQ-042 Scenario: A and B both write addr7 in one cycle, then A reads addr7 -> collision_cnt=1 and no compare (check_cnt unchanged).
REQ-043 Scenario: A writes addr2 while B reads addr2 in the same cycle -> collision_cnt=1 and no check; a later B read returns the new value and is checked.
REQ-044 Scenario: mismatches on A (addr1) and B (addr4) in one cycle, then clear -> the first capture is port A addr1, and after clear all status reads 0 while a later read of addr1 still compares against the model.
REQ-045 Scenario: rst_n pulsed low with reads in flight, then a read of unwritten addr9 -> no compares, valid cleared, and uninit_cnt=1 when MEM_CHK_UNINIT_FLAG_EN is defined.

Source files
------------

// File: rtl/mem_chk_pkg.sv
// Shared types and helpers for the dual-port memory checker.
// Pipe entries are sized for the largest supported address and data widths.
// Instances zero-extend into these fields and read back only the low bits.
package mem_chk_pkg;

    localparam int ENTRY_AW = 16;
    localparam int ENTRY_DW = 64;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_id_t;

    typedef struct packed {
        logic                valid;      // model entry was written when the read issued
        logic                collision;  // other port wrote this address in the issue cycle
        logic [ENTRY_AW-1:0] addr;
        logic [ENTRY_DW-1:0] exp;
    } pipe_entry_t;

    localparam int ENTRY_W = $bits(pipe_entry_t);

    // Add 0..2 to a counter of 'width' bits (width <= 32), clamping at all-ones.
    function automatic logic [31:0] sat_add(input logic [31:0] cur, input logic [1:0] inc,
                                            input int width);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, cur} + {31'd0, inc};
        lim = (33'd1 << width) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/chk_pipe.sv
// Fixed delay line carrying read-check entries from issue to compare.
// Latency: RD_LATENCY cycles, in to out.
// Backpressure: none; one entry may enter every cycle, reset empties all stages.
module chk_pipe #(
    parameter int RD_LATENCY = 1,
    parameter int WIDTH      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_dat
);

    logic [RD_LATENCY-1:0] vld_q;
    logic [WIDTH-1:0]      dat_q [RD_LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_vld;
            dat_q[0] <= in_dat;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign out_vld = vld_q[RD_LATENCY-1];
    assign out_dat = dat_q[RD_LATENCY-1];

endmodule

// File: rtl/dp_memory_checker.sv
// Dual-port memory checker: shadows writes in a model and checks DUT read data.
// Latency: compare in cycle t+RD_LATENCY of the read; status visible after that edge.
// Backpressure: none, passive observer. MEM_CHK_UNINIT_FLAG_EN adds uninit_cnt.
module dp_memory_checker
    import mem_chk_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int RD_LATENCY = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_din,
    input  logic [DATA_WIDTH-1:0] a_dout,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_din,
    input  logic [DATA_WIDTH-1:0] b_dout,
    input  logic                  clear,
    output logic                  err_sticky,
    output logic [CNT_WIDTH-1:0]  check_cnt,
    output logic [CNT_WIDTH-1:0]  mismatch_cnt,
    output logic [CNT_WIDTH-1:0]  collision_cnt,
    output logic                  first_err_valid,
    output logic                  first_err_port,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [DATA_WIDTH-1:0] first_err_exp,
    output logic [DATA_WIDTH-1:0] first_err_got
`ifdef MEM_CHK_UNINIT_FLAG_EN
    ,
    output logic [CNT_WIDTH-1:0]  uninit_cnt
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] model [DEPTH];
    logic [DEPTH-1:0]      vbits;
    logic [DEPTH-1:0]      vbits_nxt;
    logic                  ww_coll;
    logic                  a_rd_coll;
    logic                  b_rd_coll;
    pipe_entry_t           a_ent;
    pipe_entry_t           b_ent;
    pipe_entry_t           a_out;
    pipe_entry_t           b_out;
    logic                  a_out_vld;
    logic                  b_out_vld;
    logic                  a_do_chk;
    logic                  b_do_chk;
    logic                  a_mis;
    logic                  b_mis;
    logic [DATA_WIDTH-1:0] a_exp;
    logic [DATA_WIDTH-1:0] b_exp;
    logic [1:0]            chk_inc;
    logic [1:0]            mis_inc;
    logic [1:0]            col_inc;
    logic                  unused_pipe_bits;

    assign ww_coll   = a_we & b_we & (a_addr == b_addr);
    assign a_rd_coll = ~a_we & b_we & (a_addr == b_addr);
    assign b_rd_coll = ~b_we & a_we & (b_addr == a_addr);

    // Model is read before this cycle's writes land, so reads see old data.
    always_comb begin
        a_ent           = '0;
        a_ent.valid     = vbits[a_addr];
        a_ent.collision = a_rd_coll;
        a_ent.addr      = ENTRY_AW'(a_addr);
        a_ent.exp       = ENTRY_DW'(model[a_addr]);
        b_ent           = '0;
        b_ent.valid     = vbits[b_addr];
        b_ent.collision = b_rd_coll;
        b_ent.addr      = ENTRY_AW'(b_addr);
        b_ent.exp       = ENTRY_DW'(model[b_addr]);
    end

    always_ff @(posedge clk) begin
        if (!ww_coll) begin
            if (a_we) model[a_addr] <= a_din;
            if (b_we) model[b_addr] <= b_din;
        end
    end

    // A same-address double write leaves the content unknown, so drop validity.
    always_comb begin
        vbits_nxt = vbits;
        if (ww_coll) begin
            vbits_nxt[a_addr] = 1'b0;
        end else begin
            if (a_we) vbits_nxt[a_addr] = 1'b1;
            if (b_we) vbits_nxt[b_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vbits <= '0;
        else        vbits <= vbits_nxt;
    end

    chk_pipe #(.RD_LATENCY(RD_LATENCY), .WIDTH(ENTRY_W)) u_pipe_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (~a_we),
        .in_dat  (a_ent),
        .out_vld (a_out_vld),
        .out_dat (a_out)
    );

    chk_pipe #(.RD_LATENCY(RD_LATENCY), .WIDTH(ENTRY_W)) u_pipe_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (~b_we),
        .in_dat  (b_ent),
        .out_vld (b_out_vld),
        .out_dat (b_out)
    );

    assign unused_pipe_bits = ^{a_out, b_out};

    assign a_exp    = a_out.exp[DATA_WIDTH-1:0];
    assign b_exp    = b_out.exp[DATA_WIDTH-1:0];
    assign a_do_chk = a_out_vld & a_out.valid & ~a_out.collision;
    assign b_do_chk = b_out_vld & b_out.valid & ~b_out.collision;
    // Case inequality so X/Z on the DUT read data is flagged.
    assign a_mis    = a_do_chk & (a_dout !== a_exp);
    assign b_mis    = b_do_chk & (b_dout !== b_exp);
    assign chk_inc  = {1'b0, a_do_chk} + {1'b0, b_do_chk};
    assign mis_inc  = {1'b0, a_mis} + {1'b0, b_mis};
    assign col_inc  = {1'b0, ww_coll | a_rd_coll | b_rd_coll};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            check_cnt       <= '0;
            mismatch_cnt    <= '0;
            collision_cnt   <= '0;
            err_sticky      <= 1'b0;
            first_err_valid <= 1'b0;
            first_err_port  <= 1'b0;
            first_err_addr  <= '0;
            first_err_exp   <= '0;
            first_err_got   <= '0;
        end else if (clear) begin
            check_cnt       <= '0;
            mismatch_cnt    <= '0;
            collision_cnt   <= '0;
            err_sticky      <= 1'b0;
            first_err_valid <= 1'b0;
            first_err_port  <= 1'b0;
            first_err_addr  <= '0;
            first_err_exp   <= '0;
            first_err_got   <= '0;
        end else begin
            check_cnt     <= CNT_WIDTH'(sat_add(32'(check_cnt), chk_inc, CNT_WIDTH));
            mismatch_cnt  <= CNT_WIDTH'(sat_add(32'(mismatch_cnt), mis_inc, CNT_WIDTH));
            collision_cnt <= CNT_WIDTH'(sat_add(32'(collision_cnt), col_inc, CNT_WIDTH));
            if (a_mis || b_mis) err_sticky <= 1'b1;
            // Port A wins when both ports fail in the capturing cycle.
            if (!first_err_valid && (a_mis || b_mis)) begin
                first_err_valid <= 1'b1;
                first_err_port  <= a_mis ? PORT_A : PORT_B;
                first_err_addr  <= a_mis ? a_out.addr[ADDR_WIDTH-1:0] : b_out.addr[ADDR_WIDTH-1:0];
                first_err_exp   <= a_mis ? a_exp : b_exp;
                first_err_got   <= a_mis ? a_dout : b_dout;
            end
        end
    end

`ifdef MEM_CHK_UNINIT_FLAG_EN
    logic       a_uninit;
    logic       b_uninit;
    logic [1:0] uninit_inc;

    assign a_uninit   = a_out_vld & ~a_out.valid & ~a_out.collision;
    assign b_uninit   = b_out_vld & ~b_out.valid & ~b_out.collision;
    assign uninit_inc = {1'b0, a_uninit} + {1'b0, b_uninit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     uninit_cnt <= '0;
        else if (clear) uninit_cnt <= '0;
        else            uninit_cnt <= CNT_WIDTH'(sat_add(32'(uninit_cnt), uninit_inc, CNT_WIDTH));
    end
`endif

endmodule

// File: tb/tb_dp_memory_checker.sv
// Directed bench for dp_memory_checker (RD_LATENCY=2, 4-bit counters).
// Idle cycles write scratch addresses 14/15 on both ports so no stray reads issue.
module tb_dp_memory_checker;

    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int LAT = 2;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_we, b_we, clear;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_din, b_din, a_dout, b_dout;
    logic          err_sticky, first_err_valid, first_err_port;
    logic [CW-1:0] check_cnt, mismatch_cnt, collision_cnt;
    logic [AW-1:0] first_err_addr;
    logic [DW-1:0] first_err_exp, first_err_got;
`ifdef MEM_CHK_UNINIT_FLAG_EN
    logic [CW-1:0] uninit_cnt;
`endif

    always #5 clk = ~clk;

    dp_memory_checker #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .RD_LATENCY (LAT),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .a_we            (a_we),
        .a_addr          (a_addr),
        .a_din           (a_din),
        .a_dout          (a_dout),
        .b_we            (b_we),
        .b_addr          (b_addr),
        .b_din           (b_din),
        .b_dout          (b_dout),
        .clear           (clear),
        .err_sticky      (err_sticky),
        .check_cnt       (check_cnt),
        .mismatch_cnt    (mismatch_cnt),
        .collision_cnt   (collision_cnt),
        .first_err_valid (first_err_valid),
        .first_err_port  (first_err_port),
        .first_err_addr  (first_err_addr),
        .first_err_exp   (first_err_exp),
        .first_err_got   (first_err_got)
`ifdef MEM_CHK_UNINIT_FLAG_EN
        ,
        .uninit_cnt      (uninit_cnt)
`endif
    );

    typedef struct {
        logic          a_we;
        logic [AW-1:0] a_addr;
        logic [DW-1:0] a_din;
        logic          b_we;
        logic [AW-1:0] b_addr;
        logic [DW-1:0] b_din;
        logic [DW-1:0] a_dout;
        logic [DW-1:0] b_dout;
        logic          clr;
        logic [CW-1:0] e_chk;
        logic [CW-1:0] e_mis;
        logic [CW-1:0] e_col;
        logic          e_err;
        logic          e_fv;
        logic          e_fp;
        logic [AW-1:0] e_fa;
        logic [DW-1:0] e_fe;
        logic [DW-1:0] e_fg;
    } vec_t;

    vec_t tbl[$];
    vec_t cur;
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, got, exp);
    endtask

    task automatic idle_in();
        cur.a_we = 1'b1; cur.a_addr = 4'd14; cur.a_din = 8'h00;
        cur.b_we = 1'b1; cur.b_addr = 4'd15; cur.b_din = 8'h00;
        cur.a_dout = 8'h00; cur.b_dout = 8'h00; cur.clr = 1'b0;
    endtask

    task automatic pa(input byte op, input int ad = 0, input int dt = 0);
        cur.a_we = (op == "W"); cur.a_addr = AW'(ad); cur.a_din = DW'(dt);
    endtask

    task automatic pb(input byte op, input int ad = 0, input int dt = 0);
        cur.b_we = (op == "W"); cur.b_addr = AW'(ad); cur.b_din = DW'(dt);
    endtask

    task automatic dout(input logic [DW-1:0] da, input logic [DW-1:0] db);
        cur.a_dout = da; cur.b_dout = db;
    endtask

    task automatic ex(input int c, input int m, input int col, input int e);
        cur.e_chk = CW'(c); cur.e_mis = CW'(m); cur.e_col = CW'(col); cur.e_err = (e != 0);
    endtask

    task automatic fe(input int v, input int p, input int ad, input logic [DW-1:0] ev,
                      input logic [DW-1:0] gv);
        cur.e_fv = (v != 0); cur.e_fp = (p != 0); cur.e_fa = AW'(ad);
        cur.e_fe = ev; cur.e_fg = gv;
    endtask

    task automatic push();
        tbl.push_back(cur);
        idle_in();
    endtask

    task automatic apply(input vec_t v);
        a_we = v.a_we; a_addr = v.a_addr; a_din = v.a_din;
        b_we = v.b_we; b_addr = v.b_addr; b_din = v.b_din;
        a_dout = v.a_dout; b_dout = v.b_dout; clear = v.clr;
    endtask

    task automatic step();
        @(negedge clk);
        apply(cur);
        idle_in();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string p, input vec_t v);
        check({p, " check_cnt"},       16'(check_cnt),       16'(v.e_chk));
        check({p, " mismatch_cnt"},    16'(mismatch_cnt),    16'(v.e_mis));
        check({p, " collision_cnt"},   16'(collision_cnt),   16'(v.e_col));
        check({p, " err_sticky"},      16'(err_sticky),      16'(v.e_err));
        check({p, " first_err_valid"}, 16'(first_err_valid), 16'(v.e_fv));
        check({p, " first_err_port"},  16'(first_err_port),  16'(v.e_fp));
        check({p, " first_err_addr"},  16'(first_err_addr),  16'(v.e_fa));
        check({p, " first_err_exp"},   16'(first_err_exp),   16'(v.e_fe));
        check({p, " first_err_got"},   16'(first_err_got),   16'(v.e_fg));
    endtask

    initial begin
        idle_in();
        ex(0, 0, 0, 0);
        fe(0, 0, 0, 8'h00, 8'h00);
        apply(cur);
        rst_n = 1'b0;

        // Expected status after each vector's edge; expectations carry forward.
        // Good read on B of a written address.
        pa("W", 3, 'hA5); push();
        pb("R", 3); push();
        push();
        ex(1, 0, 0, 0); dout(8'h00, 8'hA5); push();
        // Bad read on B: first error captured.
        pb("R", 3); push();
        push();
        ex(2, 1, 0, 1); fe(1, 1, 3, 8'hA5, 8'h5A); dout(8'h00, 8'h5A); push();
        // Double write to addr7 invalidates it; the following read is skipped.
        ex(2, 1, 1, 1); pa("W", 7, 'h11); pb("W", 7, 'h22); push();
        pa("R", 7); push();
        push();
        dout(8'hFF, 8'h00); push();
        // Read colliding with other-port write is skipped; later read sees new data.
        ex(2, 1, 2, 1); pa("W", 2, 'h3C); pb("R", 2); push();
        pb("R", 2); push();
        dout(8'h00, 8'h00); push();
        ex(3, 1, 2, 1); dout(8'h00, 8'h3C); push();
        ex(0, 0, 0, 0); fe(0, 0, 0, 8'h00, 8'h00); cur.clr = 1'b1; push();
        // Simultaneous A and B mismatches: port A is captured.
        pa("W", 1, 'h11); pb("W", 4, 'h44); push();
        pa("R", 1); pb("R", 4); push();
        push();
        ex(2, 2, 0, 1); fe(1, 0, 1, 8'h11, 8'h10); dout(8'h10, 8'h40); push();
        ex(0, 0, 0, 0); fe(0, 0, 0, 8'h00, 8'h00); cur.clr = 1'b1; push();
        pa("R", 1); push();
        push();
        ex(1, 0, 0, 0); dout(8'h11, 8'h00); push();
        // Clear coincident with a compare wins.
        pa("R", 4); push();
        push();
        ex(0, 0, 0, 0); dout(8'h44, 8'h00); cur.clr = 1'b1; push();
        // A read in flight across a clear still counts afterwards.
        pb("R", 1); push();
        cur.clr = 1'b1; push();
        ex(1, 0, 0, 0); dout(8'h00, 8'h11); push();
        // X on read data is a mismatch.
        pa("R", 3); push();
        push();
        ex(2, 1, 0, 1); fe(1, 0, 3, 8'hA5, 8'hxx); dout(8'hxx, 8'h00); push();

        repeat (3) @(negedge clk);
        ex(0, 0, 0, 0); fe(0, 0, 0, 8'h00, 8'h00);
        check_status("reset", cur);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            apply(tbl[i]);
            @(posedge clk);
            #1;
            check_status($sformatf("v%0d", i), tbl[i]);
        end
        idle_in();

        // Saturation of check/mismatch counters (4-bit), then collision counter.
        cur.clr = 1'b1; step();
        pa("W", 5, 'h55); step();
        for (int k = 0; k < 10; k++) begin
            pa("R", 5); pb("R", 5); step();
        end
        step(); step();
        ex(15, 15, 0, 1); fe(1, 0, 5, 8'h55, 8'h00);
        check_status("sat_chk", cur);
        for (int k = 0; k < 20; k++) begin
            pa("W", 6, 1); pb("W", 6, 2); step();
        end
        ex(15, 15, 15, 1);
        check_status("sat_col", cur);

        // Reset pulse with reads in flight: immediate zeroing, reads discarded.
        pa("R", 3); pb("R", 1); step();
        @(negedge clk);
        apply(cur);
        #2 rst_n = 1'b0;
        #1;
        ex(0, 0, 0, 0); fe(0, 0, 0, 8'h00, 8'h00);
        check_status("rst_async", cur);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(); step();
        check_status("rst_discard", cur);
        pa("R", 9); step(); step(); step();
        check_status("rd_unwritten", cur);
`ifdef MEM_CHK_UNINIT_FLAG_EN
        check("uninit_cnt addr9", 16'(uninit_cnt), 16'd1);
`endif
        // addr3 holds A5 in the model but its valid bit was cleared by reset.
        pb("R", 3); step(); step(); step();
        check_status("rd_after_rst", cur);
`ifdef MEM_CHK_UNINIT_FLAG_EN
        check("uninit_cnt addr3", 16'(uninit_cnt), 16'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
